// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants and types for the two-requester round-robin arbiter.
// Source encoding matches the mux select: A is mux input a, B is mux input b.
package mux2_rr_arbiter_pkg;

    localparam logic SRC_A     = 1'b0;
    localparam logic SRC_B     = 1'b1;
    localparam int   DEF_WIDTH = 32;
    localparam int   DEF_CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Shared 2-to-1 datapath mux; sel picks input b, otherwise input a.
module mux_2_to_1_32bit
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] o
);

    assign o = (sel == SRC_B) ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin controller around the shared mux: picks a requester, loads a
// one-entry output buffer and keeps saturating per-source grant counters.
module mux2_rr_arbiter
    import mux2_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_src,
    input  logic             o_ready,
    output logic             sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic             r_last_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic             w_full;
    logic             w_can_load;
    logic             w_sel;
    logic             w_a_ready;
    logic             w_b_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_o;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Contention goes to whoever did not win last; an idle side never blocks the other.
    always_comb begin
        w_sel = r_last_sel;
        case ({a_valid, b_valid})
            2'b10:   w_sel = SRC_A;
            2'b01:   w_sel = SRC_B;
            2'b11:   w_sel = ~r_last_sel;
            default: w_sel = r_last_sel;
        endcase
    end

    assign w_can_load = !w_full || o_ready;
    assign w_a_ready  = !rst && w_can_load && a_valid && (w_sel == SRC_A);
    assign w_b_ready  = !rst && w_can_load && b_valid && (w_sel == SRC_B);
    assign w_xfer     = w_a_ready || w_b_ready;

    mux_2_to_1_32bit #(.WIDTH(WIDTH)) u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (w_sel),
        .o   (w_mux_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer)              w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_xfer && o_ready)  w_state_nxt = ST_EMPTY;
            default:                           w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_full = (r_state == ST_FULL);
    end

    // Buffered word and select history only move on a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_src      <= SRC_A;
            r_last_sel <= SRC_B;
        end else if (w_xfer) begin
            r_data     <= w_mux_o;
            r_src      <= w_sel;
            r_last_sel <= w_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (cnt_clr) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_a_ready) r_cnt_a <= sat_inc(r_cnt_a);
            if (w_b_ready) r_cnt_b <= sat_inc(r_cnt_b);
        end
    end

    assign a_ready = w_a_ready;
    assign b_ready = w_b_ready;
    assign sel     = w_sel;
    assign o_valid = w_full;
    assign o_data  = r_data;
    assign o_src   = r_src;
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;

endmodule
